// File: rtl/rtc_edit_pkg.sv
// Shared types and constants for the RTC/timer field editor.
package rtc_edit_pkg;

   // Editor FSM states.
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      SELECT      = 3'd1,
      HOLD_DELAY  = 3'd2,
      HOLD_REPEAT = 3'd3,
      TIMER_RUN   = 3'd4
   } editState_t;

   // Direction of an inc/dec step.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } stepDir_t;

   // Requests raised by the next-state logic and turned into pulses by the output logic.
   typedef struct packed {
      logic     step;
      stepDir_t dir;
      logic     start;
      logic     abort;
   } editEvent_t;

   // Field indices (calendar group followed by countdown timer group).
   localparam int unsigned FLD_SEG    = 0;
   localparam int unsigned FLD_MIN    = 1;
   localparam int unsigned FLD_HOUR   = 2;
   localparam int unsigned FLD_DAY    = 3;
   localparam int unsigned FLD_MONTH  = 4;
   localparam int unsigned FLD_YEAR   = 5;
   localparam int unsigned FLD_SEG_T  = 6;
   localparam int unsigned FLD_MIN_T  = 7;
   localparam int unsigned FLD_HOUR_T = 8;

   // Button vector layout.
   localparam int unsigned NUM_BTN   = 4;
   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_DOWN  = 1;
   localparam int unsigned BTN_LEFT  = 2;
   localparam int unsigned BTN_RIGHT = 3;

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for the four debounced front-panel buttons.
module btn_edge_det
   import rtc_edit_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] rise_c
);

   logic [NUM_BTN-1:0] btnPrev;

   // History follows the raw levels every cycle, regardless of enable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btnPrev <= '0;
      end else begin
         btnPrev <= btn;
      end
   end

   assign rise_c = btn & ~btnPrev;

endmodule

// File: rtl/rtc_field_editor.sv
// Button-driven editor for the RTC and countdown timer fields.
// LEFT selects a field, UP/DOWN step it (hold to auto-repeat), RIGHT commits
// or starts the timer, LEFT aborts a running timer.
module rtc_field_editor
   import rtc_edit_pkg::*;
#(
   parameter int unsigned NUM_FIELDS   = 9,
   parameter int unsigned TIMER_BASE   = 6,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 5000000,
   parameter int unsigned IDLE_TIMEOUT = 500000000,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned FIELD_W      = $clog2(NUM_FIELDS)
)
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  btn_up,
   input  logic                  btn_down,
   input  logic                  btn_left,
   input  logic                  btn_right,
   input  logic                  timer_done,
   output logic [FIELD_W-1:0]    field_sel,
   output logic                  edit_active,
   output logic [NUM_FIELDS-1:0] inc_pulse,
   output logic [NUM_FIELDS-1:0] dec_pulse,
   output logic                  wr_strobe,
   output logic                  timer_start,
   output logic                  timer_abort,
   output logic                  timer_running
);

   localparam logic [CNT_W-1:0]   DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0]   RATE_LAST   = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0]   IDLE_LAST   = CNT_W'(IDLE_TIMEOUT - 1);
   localparam logic [FIELD_W-1:0] FIELD_FIRST = FIELD_W'(FLD_SEG);
   localparam logic [FIELD_W-1:0] FIELD_LAST  = FIELD_W'(NUM_FIELDS - 1);
   localparam logic [FIELD_W-1:0] FIELD_TIMER = FIELD_W'(TIMER_BASE);

   // FSM state and datapath registers
   editState_t         state;
   editState_t         stateNext;
   logic [FIELD_W-1:0] fieldSel;
   logic [FIELD_W-1:0] fieldNext;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cntNext;
   stepDir_t           dir;
   stepDir_t           dirNext;
   editEvent_t         evt;

   // Button edges
   logic [NUM_BTN-1:0] btnVec;
   logic [NUM_BTN-1:0] btnRise;
   logic               upEdge;
   logic               downEdge;
   logic               leftEdge;
   logic               rightEdge;
   logic               dirHeld;
   logic               oppEdge;

   // Next values of the registered outputs
   logic [NUM_FIELDS-1:0] stepVec;
   logic [NUM_FIELDS-1:0] incNext;
   logic [NUM_FIELDS-1:0] decNext;
   logic                  wrNext;
   logic                  startNext;
   logic                  abortNext;
   logic                  editActiveNext;
   logic                  timerRunningNext;

   assign btnVec = {btn_right, btn_left, btn_down, btn_up};

   btn_edge_det u_edge (
      .clock  (clock),
      .reset  (reset),
      .btn    (btnVec),
      .rise_c (btnRise)
   );

   assign upEdge    = btnRise[BTN_UP];
   assign downEdge  = btnRise[BTN_DOWN];
   assign leftEdge  = btnRise[BTN_LEFT];
   assign rightEdge = btnRise[BTN_RIGHT];

   // Level of the button being repeated, and a fresh press of the other one.
   assign dirHeld = (dir == DIR_UP) ? btn_up : btn_down;
   assign oppEdge = (dir == DIR_UP) ? downEdge : upEdge;

   // State register; en=0 is folded into the next-state logic as a hold.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         fieldSel <= FIELD_FIRST;
         cnt      <= '0;
         dir      <= DIR_UP;
      end else begin
         state    <= stateNext;
         fieldSel <= fieldNext;
         cnt      <= cntNext;
         dir      <= dirNext;
      end
   end

   // Next-state logic; one shared counter serves as idle timeout and repeat timer.
   always_comb begin
      stateNext = state;
      fieldNext = fieldSel;
      cntNext   = cnt;
      dirNext   = dir;
      evt       = '0;
      evt.dir   = dir;

      if (en) begin
         unique case (state)
            IDLE: begin
               if (leftEdge) begin
                  stateNext = SELECT;
                  fieldNext = FIELD_FIRST;
                  cntNext   = '0;
               end
            end

            SELECT: begin
               cntNext = '0;
               if (leftEdge) begin
                  fieldNext = (fieldSel == FIELD_LAST) ? FIELD_FIRST : fieldSel + FIELD_W'(1);
               end else if (rightEdge) begin
                  if (fieldSel >= FIELD_TIMER) begin
                     evt.start = 1'b1;
                     stateNext = TIMER_RUN;
                  end else begin
                     stateNext = IDLE;
                  end
               end else if (upEdge) begin
                  if (!btn_down) begin
                     evt.step  = 1'b1;
                     evt.dir   = DIR_UP;
                     dirNext   = DIR_UP;
                     stateNext = HOLD_DELAY;
                  end
               end else if (downEdge) begin
                  if (!btn_up) begin
                     evt.step  = 1'b1;
                     evt.dir   = DIR_DOWN;
                     dirNext   = DIR_DOWN;
                     stateNext = HOLD_DELAY;
                  end
               end else if (cnt == IDLE_LAST) begin
                  stateNext = IDLE;
               end else begin
                  cntNext = cnt + CNT_W'(1);
               end
            end

            HOLD_DELAY: begin
               if (!dirHeld) begin
                  stateNext = SELECT;
                  cntNext   = '0;
               end else if (cnt == DELAY_LAST) begin
                  evt.step  = 1'b1;
                  stateNext = HOLD_REPEAT;
                  cntNext   = '0;
               end else begin
                  cntNext = cnt + CNT_W'(1);
               end
            end

            HOLD_REPEAT: begin
               if (!dirHeld || oppEdge) begin
                  stateNext = SELECT;
                  cntNext   = '0;
               end else if (cnt == RATE_LAST) begin
                  evt.step = 1'b1;
                  cntNext  = '0;
               end else begin
                  cntNext = cnt + CNT_W'(1);
               end
            end

            TIMER_RUN: begin
               if (timer_done) begin
                  stateNext = IDLE;
                  cntNext   = '0;
               end else if (leftEdge) begin
                  evt.abort = 1'b1;
                  stateNext = SELECT;
                  cntNext   = '0;
               end
            end

            default: begin
               stateNext = IDLE;
               cntNext   = '0;
            end
         endcase
      end
   end

   // Output decode: one-hot step to the selected field plus level flags.
   always_comb begin
      stepVec          = NUM_FIELDS'(1) << fieldSel;
      incNext          = '0;
      decNext          = '0;
      wrNext           = evt.step;
      startNext        = evt.start;
      abortNext        = evt.abort;
      editActiveNext   = (stateNext == SELECT) || (stateNext == HOLD_DELAY) ||
                         (stateNext == HOLD_REPEAT);
      timerRunningNext = (stateNext == TIMER_RUN);
      if (evt.step) begin
         if (evt.dir == DIR_UP) begin
            incNext = stepVec;
         end else begin
            decNext = stepVec;
         end
      end
   end

   // Output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         inc_pulse     <= '0;
         dec_pulse     <= '0;
         wr_strobe     <= 1'b0;
         timer_start   <= 1'b0;
         timer_abort   <= 1'b0;
         edit_active   <= 1'b0;
         timer_running <= 1'b0;
      end else begin
         inc_pulse     <= incNext;
         dec_pulse     <= decNext;
         wr_strobe     <= wrNext;
         timer_start   <= startNext;
         timer_abort   <= abortNext;
         edit_active   <= editActiveNext;
         timer_running <= timerRunningNext;
      end
   end

   assign field_sel = fieldSel;

endmodule

// File: tb/tb_rtc_field_editor.sv
// Scoreboard bench for rtc_field_editor: directed scenarios plus random button traffic.
module tb_rtc_field_editor;

   localparam int unsigned NF    = 9;
   localparam int unsigned TBASE = 6;
   localparam int unsigned RD    = 8;
   localparam int unsigned RR    = 4;
   localparam int unsigned TO    = 50;
   localparam int unsigned FW    = $clog2(NF);

   localparam int M_OFF   = 0;
   localparam int M_EDIT  = 1;
   localparam int M_HOLD  = 2;
   localparam int M_TIMER = 3;

   typedef struct packed {
      logic [FW-1:0] fld;
      logic          edit;
      logic [NF-1:0] inc;
      logic [NF-1:0] dec;
      logic          wr;
      logic          start;
      logic          abort;
      logic          running;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          en;
   logic          btn_up;
   logic          btn_down;
   logic          btn_left;
   logic          btn_right;
   logic          timer_done;
   logic [FW-1:0] field_sel;
   logic          edit_active;
   logic [NF-1:0] inc_pulse;
   logic [NF-1:0] dec_pulse;
   logic          wr_strobe;
   logic          timer_start;
   logic          timer_abort;
   logic          timer_running;

   int   checks   = 0;
   int   errors   = 0;
   int   decSeen0 = 0;
   exp_t expQ[$];

   // Reference model state: mode, selected field, quiet cycles in edit, cycles since first step.
   int   mode;
   int   mFld;
   int   idleCnt;
   int   heldCnt;
   bit   hUp;
   bit   pU, pD, pL, pR;

   rtc_field_editor #(
      .NUM_FIELDS   (NF),
      .TIMER_BASE   (TBASE),
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR),
      .IDLE_TIMEOUT (TO),
      .CNT_W        (32)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .en            (en),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .timer_done    (timer_done),
      .field_sel     (field_sel),
      .edit_active   (edit_active),
      .inc_pulse     (inc_pulse),
      .dec_pulse     (dec_pulse),
      .wr_strobe     (wr_strobe),
      .timer_start   (timer_start),
      .timer_abort   (timer_abort),
      .timer_running (timer_running)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic modelReset();
      mode    = M_OFF;
      mFld    = 0;
      idleCnt = 0;
      heldCnt = 0;
      hUp     = 1'b1;
      pU = 0; pD = 0; pL = 0; pR = 0;
   endtask

   // Predict the outputs after the coming clock edge from the levels now on the inputs.
   task automatic modelStep();
      exp_t e;
      bit   eU, eD, eL, eR, held, opp, doStep;
      eU = btn_up & ~pU;
      eD = btn_down & ~pD;
      eL = btn_left & ~pL;
      eR = btn_right & ~pR;
      pU = btn_up; pD = btn_down; pL = btn_left; pR = btn_right;
      e      = '0;
      doStep = 1'b0;
      if (en) begin
         case (mode)
            M_OFF: begin
               if (eL) begin
                  mode = M_EDIT; mFld = 0; idleCnt = 0;
               end
            end
            M_EDIT: begin
               if (eL) begin
                  mFld = (mFld + 1) % NF; idleCnt = 0;
               end else if (eR) begin
                  if (mFld >= int'(TBASE)) begin
                     e.start = 1'b1; mode = M_TIMER;
                  end else begin
                     mode = M_OFF;
                  end
               end else if (eU || eD) begin
                  idleCnt = 0;
                  if (eU && !btn_down) begin
                     doStep = 1'b1; hUp = 1'b1; mode = M_HOLD; heldCnt = 0;
                  end else if (eD && !btn_up) begin
                     doStep = 1'b1; hUp = 1'b0; mode = M_HOLD; heldCnt = 0;
                  end
               end else begin
                  idleCnt++;
                  if (idleCnt == int'(TO)) mode = M_OFF;
               end
            end
            M_HOLD: begin
               heldCnt++;
               held = hUp ? btn_up : btn_down;
               opp  = hUp ? eD : eU;
               if (!held || (heldCnt > int'(RD) && opp)) begin
                  mode = M_EDIT; idleCnt = 0;
               end else if (heldCnt >= int'(RD) && ((heldCnt - int'(RD)) % int'(RR)) == 0) begin
                  doStep = 1'b1;
               end
            end
            default: begin
               if (timer_done) begin
                  mode = M_OFF;
               end else if (eL) begin
                  e.abort = 1'b1; mode = M_EDIT; idleCnt = 0;
               end
            end
         endcase
      end
      if (doStep) begin
         e.wr = 1'b1;
         if (hUp) e.inc[mFld] = 1'b1;
         else     e.dec[mFld] = 1'b1;
      end
      e.fld     = FW'(mFld);
      e.edit    = (mode == M_EDIT) || (mode == M_HOLD);
      e.running = (mode == M_TIMER);
      expQ.push_back(e);
   endtask

   // Apply one cycle of inputs at the falling edge and queue the prediction.
   task automatic driveCycle(input bit u, input bit d, input bit l, input bit r,
                             input bit dn, input bit e);
      @(negedge clock);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r; timer_done = dn; en = e;
      modelStep();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) driveCycle(0, 0, 0, 0, 0, 1);
   endtask

   task automatic pressLeft();
      driveCycle(0, 0, 1, 0, 0, 1);
      driveCycle(0, 0, 0, 0, 0, 1);
   endtask

   task automatic settle();
      @(posedge clock);
      #2;
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "_field_sel"}, 32'(field_sel), 0);
      check({tag, "_edit_active"}, 32'(edit_active), 0);
      check({tag, "_inc_pulse"}, 32'(inc_pulse), 0);
      check({tag, "_dec_pulse"}, 32'(dec_pulse), 0);
      check({tag, "_wr_strobe"}, 32'(wr_strobe), 0);
      check({tag, "_timer_start"}, 32'(timer_start), 0);
      check({tag, "_timer_abort"}, 32'(timer_abort), 0);
      check({tag, "_timer_running"}, 32'(timer_running), 0);
   endtask

   // Monitor: compare every registered output against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (dec_pulse[0] === 1'b1) decSeen0++;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("field_sel", 32'(field_sel), 32'(e.fld));
            check("edit_active", 32'(edit_active), 32'(e.edit));
            check("inc_pulse", 32'(inc_pulse), 32'(e.inc));
            check("dec_pulse", 32'(dec_pulse), 32'(e.dec));
            check("wr_strobe", 32'(wr_strobe), 32'(e.wr));
            check("timer_start", 32'(timer_start), 32'(e.start));
            check("timer_abort", 32'(timer_abort), 32'(e.abort));
            check("timer_running", 32'(timer_running), 32'(e.running));
         end
      end
   end

   initial begin
      bit u, d, l, r, dn, e;
      reset = 1'b0; en = 1'b1;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; timer_done = 0;
      modelReset();
      repeat (3) @(posedge clock);
      #1;
      checkAllZero("reset");
      @(negedge clock);
      reset = 1'b1;

      // Enter SELECT, then walk every field and wrap.
      pressLeft();
      settle();
      check("sel_entry_edit", 32'(edit_active), 1);
      check("sel_entry_field", 32'(field_sel), 0);
      repeat (8) pressLeft();
      settle();
      check("sel_field_last", 32'(field_sel), 8);
      pressLeft();
      settle();
      check("sel_field_wrap", 32'(field_sel), 0);

      // Single up tap on field 2.
      repeat (2) pressLeft();
      driveCycle(1, 0, 0, 0, 0, 1);
      idle(4);

      // Down held 30 cycles on field 0: first step then auto-repeat.
      repeat (7) pressLeft();
      decSeen0 = 0;
      repeat (30) driveCycle(0, 1, 0, 0, 0, 1);
      idle(8);
      settle();
      check("hold_dec_count", 32'(decSeen0), 7);

      // Timer start/abort on field 7, then timer_done beating a left edge.
      repeat (7) pressLeft();
      driveCycle(0, 0, 0, 1, 0, 1);
      settle();
      check("timer_run_level", 32'(timer_running), 1);
      driveCycle(0, 0, 0, 0, 0, 1);
      driveCycle(0, 0, 1, 0, 0, 1);
      settle();
      check("abort_field", 32'(field_sel), 7);
      check("abort_edit", 32'(edit_active), 1);
      driveCycle(0, 0, 0, 0, 0, 1);
      driveCycle(0, 0, 0, 1, 0, 1);
      driveCycle(0, 0, 0, 0, 0, 1);
      driveCycle(0, 0, 1, 0, 1, 1);
      settle();
      check("done_wins_edit", 32'(edit_active), 0);
      check("done_wins_abort", 32'(timer_abort), 0);
      idle(2);

      // Inactivity timeout, then en gating and a held button across en rising.
      pressLeft();
      idle(55);
      settle();
      check("timeout_edit", 32'(edit_active), 0);
      repeat (3) driveCycle(0, 0, 1, 0, 0, 0);
      repeat (3) driveCycle(0, 0, 1, 0, 0, 1);
      settle();
      check("held_across_en", 32'(edit_active), 0);
      driveCycle(0, 0, 0, 0, 0, 1);

      // Async reset while auto-repeating.
      pressLeft();
      repeat (15) driveCycle(1, 0, 0, 0, 0, 1);
      @(posedge clock);
      #2;
      reset = 1'b0;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; timer_done = 0;
      #1;
      checkAllZero("async_reset");
      modelReset();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      // Up and down together give no step.
      pressLeft();
      driveCycle(1, 1, 0, 0, 0, 1);
      driveCycle(1, 1, 0, 0, 0, 1);
      idle(3);

      // Random button traffic.
      u = 0; d = 0; l = 0; r = 0; e = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0)  u = ~u;
         if ($urandom_range(0, 9) == 0)  d = ~d;
         if ($urandom_range(0, 11) == 0) l = ~l;
         if ($urandom_range(0, 19) == 0) r = ~r;
         dn = ($urandom_range(0, 24) == 0);
         if (e) begin
            if ($urandom_range(0, 59) == 0) e = 1'b0;
         end else begin
            if ($urandom_range(0, 4) == 0) e = 1'b1;
         end
         driveCycle(u, d, l, r, dn, e);
      end

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 5 && expQ.size() != 0; i++) @(posedge clock);
      #2;
      check("scoreboard_drain", 32'(expQ.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_field_editor.md
Name: rtc_field_editor

Overview:
- Parametrised button-driven editor FSM for the RTC/timer setting path.
- Sits between the debounced front-panel buttons and the per-field time counters (sec/min/hour/day/month/year plus timer sec/min/hour).
- Selects a field with LEFT and emits one-cycle inc/dec pulses to that field's counter on UP/DOWN, with hold-to-auto-repeat.
- Starts or aborts the countdown timer with RIGHT/LEFT, and returns to idle after an inactivity timeout.

Parameters:
- NUM_FIELDS, 9, number of editable fields; field index 0..NUM_FIELDS-1.
- TIMER_BASE, 6, first field index that belongs to the timer group; must be <= NUM_FIELDS-1.
- REPEAT_DELAY, 25000000, cycles UP/DOWN must stay held after the first pulse before auto-repeat begins; must be >= 2.
- REPEAT_RATE, 5000000, cycles between auto-repeat pulses; must be >= 1.
- IDLE_TIMEOUT, 500000000, cycles with no button edge in SELECT before falling back to IDLE.
- CNT_W, 32, width of the internal delay/timeout counters; must hold max(REPEAT_DELAY, REPEAT_RATE, IDLE_TIMEOUT).
- FIELD_W, $clog2(NUM_FIELDS), width of field_sel (derived).

Ports:
- clock, in, 1, system clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- en, in, 1, global enable; low freezes the FSM and all counters.
- btn_up, in, 1, level; already synchronised and debounced.
- btn_down, in, 1, level; already synchronised and debounced.
- btn_left, in, 1, level; already synchronised and debounced.
- btn_right, in, 1, level; already synchronised and debounced.
- timer_done, in, 1, countdown timer reached zero; single-cycle or level.
- field_sel, out, FIELD_W, currently selected field (address for display/RAM).
- edit_active, out, 1, high in SELECT, HOLD_DELAY and HOLD_REPEAT.
- inc_pulse, out, NUM_FIELDS, one-hot one-cycle increment request.
- dec_pulse, out, NUM_FIELDS, one-hot one-cycle decrement request.
- wr_strobe, out, 1, one cycle, coincident with any inc/dec pulse.
- timer_start, out, 1, one-cycle pulse.
- timer_abort, out, 1, one-cycle pulse.
- timer_running, out, 1, high in TIMER_RUN.

Behaviour:
- Reset (reset=0, async): state=IDLE, field_sel=0, all counters 0, all outputs 0, button history regs 0.
- All outputs are registered. Edge = btn & ~btn_prev. Any resulting pulse is high for exactly one cycle, starting at the clock edge that samples the edge.
- en=0: state, field_sel and counters hold; all pulse outputs 0; level outputs hold. btn_prev keeps tracking, so a button already held when en rises produces no edge.
- IDLE: left edge -> SELECT, field_sel=0. All other inputs are ignored.
- SELECT, one event per cycle, priority left > right > up > down:
  - left edge: field_sel += 1, wrapping NUM_FIELDS-1 -> 0.
  - right edge, field_sel >= TIMER_BASE: timer_start pulse -> TIMER_RUN.
  - right edge, field_sel < TIMER_BASE: -> IDLE (commit/exit).
  - up edge, btn_down=0: inc_pulse[field_sel] + wr_strobe -> HOLD_DELAY, dir=up, counter cleared.
  - down edge, btn_up=0: dec_pulse[field_sel] + wr_strobe -> HOLD_DELAY, dir=down.
  - up and down both high: ignored, no pulse.
  - Timeout counter increments every cycle without an edge and clears on any edge. On reaching IDLE_TIMEOUT-1 -> IDLE, field_sel kept.
- HOLD_DELAY: the dir button is released -> SELECT. Counter reaches REPEAT_DELAY-1 -> pulse (same field, same dir) -> HOLD_REPEAT, counter cleared. A left/right edge here is ignored.
- HOLD_REPEAT: one pulse every REPEAT_RATE cycles while the dir button is held; release -> SELECT with no further pulse. The opposite button rising while held: stop repeating -> SELECT, no pulse.
- The idle timeout is cleared on entry to SELECT from HOLD_*.
- TIMER_RUN: timer_done=1 -> IDLE. Otherwise a left edge gives a timer_abort pulse -> SELECT with field_sel unchanged. timer_done and a left edge in the same cycle: timer_done wins, no abort.
- Only field_sel is ever pulsed; inc_pulse and dec_pulse are never non-zero in the same cycle.

Decomposition:
- Package rtc_edit_pkg holds:
  - state enum: IDLE, SELECT, HOLD_DELAY, HOLD_REPEAT, TIMER_RUN.
  - field index constants: FLD_SEG=0, FLD_MIN=1, FLD_HOUR=2, FLD_DAY=3, FLD_MONTH=4, FLD_YEAR=5, FLD_SEG_T=6, FLD_MIN_T=7, FLD_HOUR_T=8.
  - dir enum.
- One sub-module, btn_edge_det: 4-bit history register plus rising-edge vector, with the same clock/reset.

Test Plan (bench parameters NUM_FIELDS=9, TIMER_BASE=6, REPEAT_DELAY=8, REPEAT_RATE=4, IDLE_TIMEOUT=50):
- Reset then left pulse: edit_active=1 and field_sel=0. Eight more left edges give field_sel=8; the ninth wraps to 0.
- field_sel=2, up held 1 cycle: inc_pulse=9'b000000100 and wr_strobe for exactly one cycle, no repeat.
- field_sel=0, down held 30 cycles: dec_pulse[0] at t=1, 9, 13, 17, 21, 25, 29 (7 pulses); none after release.
- field_sel=7, right edge: timer_start 1 cycle, timer_running=1. Left edge gives timer_abort and SELECT with field_sel=7. Retrigger, then timer_done plus left in the same cycle: IDLE, no timer_abort.
- SELECT with no buttons for 50 cycles: IDLE with edit_active=0. Then en=0 with a left edge gives no change; raising en while left is still held gives no edge.
- Async reset mid-HOLD_REPEAT: all outputs 0 immediately and state=IDLE; up+down simultaneous in SELECT gives no pulse.
